// File: rtl/mem_pkg.sv
// mem_pkg: widths and word type shared by the data memory, instruction memory and register file.
package mem_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 64;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: load/store bus between the MEM stage (master) and the data memory (slave).
interface data_memory_if #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] read_data;
    modport master (output address, write_data, mem_read, mem_write, input read_data);
    modport slave  (input address, write_data, mem_read, mem_write, output read_data);
endinterface

// File: rtl/mem_array.sv
// mem_array: word storage with asynchronous clear, one synchronous write port and one combinational read port.
module mem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/data_memory.sv
// data_memory: word-indexed MEM-stage data memory; addresses beyond DEPTH are dropped on write and read as zero.
module data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input logic            clk,
    input logic            rst_n,
    data_memory_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              in_range;
    logic              we;
    logic [DATA_W-1:0] rdata;

    // Upper address bits must be zero; no aliasing onto low words.
    assign in_range = (bus.address >> IDX_W) == '0;
    assign we       = (bus.mem_write == 1'b1) && in_range;

    mem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .idx   (bus.address[IDX_W-1:0]),
        .wdata (bus.write_data),
        .rdata (rdata)
    );

    always_comb bus.read_data = (bus.mem_read && in_range) ? rdata : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed stimulus feeding a scoreboard queue; a monitor compares read_data on each sample request.
module tb_data_memory;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;
    bit   done = 1'b0;

    word_t exp_q[$];
    string name_q[$];
    event  sample_ev;

    data_memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    data_memory #(.DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input word_t exp);
        exp_q.push_back(exp);
        name_q.push_back(name);
        -> sample_ev;
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input word_t d);
        @(negedge clk);
        bus.address = a;
        bus.write_data = d;
        bus.mem_write = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
    endtask

    task automatic rd(input string name, input logic [ADDR_W-1:0] a, input word_t exp);
        @(negedge clk);
        bus.address = a;
        bus.mem_read = 1'b1;
        bus.mem_write = 1'b0;
        #1;
        chk(name, exp);
    endtask

    initial begin
        forever begin
            @(sample_ev);
            if (exp_q.size() != 0) begin
                word_t e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (bus.read_data === e) passed++;
                else $display("FAIL %s: read_data=%h expected=%h", n, bus.read_data, e);
            end
        end
    end

    initial begin
        bus.address = '0;
        bus.write_data = '0;
        bus.mem_read = 1'b1;
        bus.mem_write = 1'b0;
        #2;
        chk("reset_read", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("post_reset_read", 64'd6, 32'h0);

        wr(64'd6, 32'd100);
        rd("write_then_read_6", 64'd6, 32'd100);

        bus.mem_read = 1'b0;
        #1;
        chk("gated_read", 32'h0);
        bus.mem_read = 1'b1;
        #1;
        chk("ungated_read", 32'd100);

        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.write_data = 32'd55;
        #1;
        chk("rw_before_edge", 32'd100);
        @(posedge clk);
        #1;
        chk("rw_after_edge", 32'd55);
        bus.mem_write = 1'b0;

        wr(64'd0, 32'h1234_5678);
        wr(64'd256, 32'hDEAD_BEEF);
        rd("oor_read_256", 64'd256, 32'h0);
        rd("no_alias_word0", 64'd0, 32'h1234_5678);
        rd("oor_read_high_bit", 64'h8000_0000_0000_0006, 32'h0);

        wr(64'd3, 32'd7);
        rd("read_3_before_reset", 64'd3, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_clears_3", 32'h0);
        bus.address = 64'd6;
        #1;
        chk("async_reset_clears_6", 32'h0);
        bus.address = 64'd3;
        bus.write_data = 32'd9;
        bus.mem_write = 1'b1;
        @(posedge clk);
        #1;
        chk("write_blocked_in_reset", 32'h0);
        @(negedge clk);
        bus.mem_write = 1'b0;
        rst_n = 1'b1;
        rd("read_3_after_reset", 64'd3, 32'h0);

        wr(64'd255, 32'hFFFF_FFFF);
        wr(64'd0, 32'h1);
        rd("boundary_255", 64'd255, 32'hFFFF_FFFF);
        rd("boundary_0", 64'd0, 32'h1);
        rd("neighbour_254", 64'd254, 32'h0);
        rd("neighbour_1", 64'd1, 32'h0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end
        done = 1'b1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: sim_time=%0t limit=20000", $time);
            $fatal(1);
        end
    end
endmodule
